// File: rtl/biquad_pkg.sv
// Shared types, default widths and the output saturation helper for the
// time-multiplexed biquad filter.
package biquad_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int COEF_W_DEF    = 18;
  localparam int COEF_FRAC_DEF = 16;
  localparam int NUM_CH_DEF    = 2;
  localparam int ACC_W_DEF     = 40;
  localparam int NUM_TAPS      = 5;

  typedef enum logic [2:0] {
    COEF_B0 = 3'd0,
    COEF_B1 = 3'd1,
    COEF_B2 = 3'd2,
    COEF_A1 = 3'd3,
    COEF_A2 = 3'd4
  } coef_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/biquad_mac.sv
// Shared signed multiply-accumulate unit: clear loads the first product,
// sub selects subtraction for the feedback (a) taps.
module biquad_mac
  import biquad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     sub,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  // Product, then accumulate or subtract onto a cleared or running base.
  always_comb begin
    sample_ext = {{COEF_W{sample_i[DATA_W-1]}}, sample_i};
    coef_ext   = {{DATA_W{coef_i[COEF_W-1]}}, coef_i};
    prod       = sample_ext * coef_ext;
    prod_ext   = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    if (clr) begin
      base = '0;
    end else begin
      base = acc_q;
    end
    if (!en) begin
      acc_d = acc_q;
    end else if (sub) begin
      acc_d = base - prod_ext;
    end else begin
      acc_d = base + prod_ext;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/biquad_filter_tdm.sv
// Multi-channel Direct Form I biquad with double-buffered coefficients and a
// single MAC shared across 5 taps per channel per frame.
module biquad_filter_tdm
  import biquad_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int COEF_FRAC = COEF_FRAC_DEF,
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  input  logic                     bypass,
  input  logic                     coef_we,
  input  logic [2:0]               coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic [NUM_CH*DATA_W-1:0] sample_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic signed [COEF_W-1:0] COEF_ONE =
    {{(COEF_W-COEF_FRAC-1){1'b0}}, 1'b1, {COEF_FRAC{1'b0}}};
  localparam logic signed [ACC_W-1:0] ROUND_C =
    {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef logic signed [DATA_W-1:0] smp_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [2:0]        tap_q, tap_d;
  logic              bypass_q, bypass_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic [NUM_CH*DATA_W-1:0] sample_out_q, sample_out_d;

  smp_t  x_q [NUM_CH];
  smp_t  x_d [NUM_CH];
  smp_t  x1_q[NUM_CH];
  smp_t  x1_d[NUM_CH];
  smp_t  x2_q[NUM_CH];
  smp_t  x2_d[NUM_CH];
  smp_t  y1_q[NUM_CH];
  smp_t  y1_d[NUM_CH];
  smp_t  y2_q[NUM_CH];
  smp_t  y2_d[NUM_CH];
  smp_t  yo_q[NUM_CH];
  smp_t  yo_d[NUM_CH];
  coef_t shadow_q[NUM_TAPS];
  coef_t shadow_d[NUM_TAPS];
  coef_t active_q[NUM_TAPS];
  coef_t active_d[NUM_TAPS];

  logic                     mac_clr, mac_en, mac_sub;
  smp_t                     mac_sample;
  coef_t                    mac_coef;
  logic signed [ACC_W-1:0]  mac_acc;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [63:0]       acc_sat;
  smp_t                     y_new;

  biquad_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (mac_clr),
    .en       (mac_en),
    .sub      (mac_sub),
    .sample_i (mac_sample),
    .coef_i   (mac_coef),
    .acc_o    (mac_acc)
  );

  // Tap operand select; the a-taps are subtracted.
  always_comb begin
    mac_en     = (state_q == ST_MAC);
    mac_clr    = (tap_q == 3'd0);
    mac_sub    = 1'b0;
    mac_sample = '0;
    mac_coef   = '0;
    case (tap_q)
      3'd0: begin
        mac_sample = x_q[ch_q];
        mac_coef   = active_q[COEF_B0];
      end
      3'd1: begin
        mac_sample = x1_q[ch_q];
        mac_coef   = active_q[COEF_B1];
      end
      3'd2: begin
        mac_sample = x2_q[ch_q];
        mac_coef   = active_q[COEF_B2];
      end
      3'd3: begin
        mac_sample = y1_q[ch_q];
        mac_coef   = active_q[COEF_A1];
        mac_sub    = 1'b1;
      end
      3'd4: begin
        mac_sample = y2_q[ch_q];
        mac_coef   = active_q[COEF_A2];
        mac_sub    = 1'b1;
      end
      default: begin
        mac_sample = '0;
        mac_coef   = '0;
      end
    endcase
  end

  // Round half-up, shift back to sample scale, saturate.
  always_comb begin
    acc_rnd = mac_acc + ROUND_C;
    acc_shr = acc_rnd >>> COEF_FRAC;
    acc_sat = saturate({{(64-ACC_W){acc_shr[ACC_W-1]}}, acc_shr}, DATA_W);
    if (bypass_q) begin
      y_new = x_q[ch_q];
    end else begin
      y_new = acc_sat[DATA_W-1:0];
    end
  end

  // Frame sequencer, coefficient banks and channel history.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    tap_d        = tap_q;
    bypass_d     = bypass_q;
    busy_d       = busy_q;
    out_valid_d  = 1'b0;
    overrun_d    = overrun_q | (sample_valid & (state_q != ST_IDLE));
    sample_out_d = sample_out_q;
    x_d          = x_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    y1_d         = y1_q;
    y2_d         = y2_q;
    yo_d         = yo_q;
    active_d     = active_q;
    shadow_d     = shadow_q;

    if (coef_we && (coef_addr <= 3'd4)) begin
      shadow_d[coef_addr] = coef_data;
    end else begin
      shadow_d = shadow_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          state_d  = ST_MAC;
          busy_d   = 1'b1;
          ch_d     = '0;
          tap_d    = 3'd0;
          bypass_d = bypass;
          active_d = shadow_q;
          for (int c = 0; c < NUM_CH; c++) begin
            x_d[c] = sample_in[c*DATA_W +: DATA_W];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (tap_q == 3'd4) begin
          tap_d   = 3'd0;
          state_d = ST_STORE;
        end else begin
          tap_d   = tap_q + 3'd1;
        end
      end
      ST_STORE: begin
        yo_d[ch_q] = y_new;
        x2_d[ch_q] = x1_q[ch_q];
        x1_d[ch_q] = x_q[ch_q];
        y2_d[ch_q] = y1_q[ch_q];
        y1_d[ch_q] = y_new;
        if (ch_q < LAST_CH) begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ST_MAC;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        for (int c = 0; c < NUM_CH; c++) begin
          sample_out_d[c*DATA_W +: DATA_W] = yo_q[c];
        end
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; coefficient banks reset to unity pass-through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      tap_q        <= 3'd0;
      bypass_q     <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      sample_out_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        x_q[c]  <= '0;
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
        yo_q[c] <= '0;
      end
      for (int t = 0; t < NUM_TAPS; t++) begin
        shadow_q[t] <= (t == 0) ? COEF_ONE : '0;
        active_q[t] <= (t == 0) ? COEF_ONE : '0;
      end
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      tap_q        <= tap_d;
      bypass_q     <= bypass_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      sample_out_q <= sample_out_d;
      x_q          <= x_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      y1_q         <= y1_d;
      y2_q         <= y2_d;
      yo_q         <= yo_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/biquad_filter_tdm.md
Name: biquad_filter_tdm

Overview:
- Parametrised successor to the fixed single-channel lowpass: runtime-programmable Direct Form I biquad (LP/HP/BP/shelf by coefficients) for NUM_CH audio channels.
- One shared multiply-accumulate unit, time-multiplexed across 5 taps × NUM_CH channels per sample frame.
- Sits in the channel strip between the input gain stage and the dynamics stage; driven by a per-frame sample strobe, running many clk cycles per sample period.

Parameters:
DATA_W, 16, signed sample width per channel
COEF_W, 18, signed coefficient width
COEF_FRAC, 16, coefficient fractional bits (Q2.16: range −2.0 … +1.99998)
NUM_CH, 2, audio channels processed per frame
ACC_W, 40, accumulator width (≥ DATA_W+COEF_W+3)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sample_valid  in  1  one-cycle strobe: new frame present on sample_in
sample_in  in  NUM_CH*DATA_W  signed samples, channel 0 in LSBs
bypass  in  1  pass-through mode, sampled when a frame is accepted
coef_we  in  1  coefficient write strobe
coef_addr  in  3  0=b0 1=b1 2=b2 3=a1 4=a2; 5–7 ignored
coef_data  in  COEF_W  signed coefficient value
sample_out  out  NUM_CH*DATA_W  filtered samples, channel 0 in LSBs
out_valid  out  1  one-cycle pulse: sample_out updated
busy  out  1  frame in progress
overrun  out  1  sticky: sample_valid arrived while busy

Behaviour:
- Reset, asynchronous with reset_n low:
  - sample_out=0, out_valid=0, busy=0, overrun=0.
  - All history (x1, x2, y1, y2 per channel) = 0.
  - Active and shadow coefficients: b0=1<<COEF_FRAC; b1=b2=a1=a2=0. This is unity pass-through.
  - FSM = IDLE.
- Coefficients:
  - coef_we writes the shadow bank at any time.
  - The shadow bank is copied to the active bank only on the edge that accepts a frame.
  - A write on that same edge lands in shadow and does not take effect until the next frame.
- Equation per channel: y = round((b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2) >> COEF_FRAC).
  - Rounding: add 2^(COEF_FRAC−1), then arithmetic shift.
  - Result saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - The accumulator never wraps at ACC_W=40.
- FSM states:
  - IDLE: on sample_valid, latch sample_in, bypass and coefficients; set busy=1; channel=0, tap=0; go to MAC.
  - MAC: one product accumulated per cycle, taps 0..4. The accumulator is cleared at tap 0. After tap 4, go to STORE.
  - STORE:
    - Round and saturate the result into the channel's output register.
    - Shift history: x2←x1, x1←x, y2←y1, y1←y.
    - If channel<NUM_CH−1: channel+1, go to MAC. Otherwise go to DONE.
  - DONE: drive sample_out from the output registers; pulse out_valid; busy=0; go to IDLE.
- Latency: out_valid asserts exactly 6·NUM_CH+1 edges after the accepting edge (13 at default). sample_out holds its value until the next DONE.
- bypass=1:
  - y = x, with identical latency and out_valid timing.
  - History is still updated with y1=x, so there is no transient on return to filter mode.
- Overrun:
  - sample_valid while busy=1 is dropped and sets overrun, which clears only on reset.
  - sample_valid on the DONE cycle is dropped.
  - sample_valid on the IDLE cycle after DONE is accepted.
- Reset mid-frame aborts immediately:
  - No out_valid.
  - All state returns to its reset values.

Decomposition:
- Shared package biquad_pkg:
  - coefficient index enum (B0, B1, B2, A1, A2);
  - FSM state enum;
  - default widths as localparams;
  - a saturate function.
- One sub-module, biquad_mac: signed multiplier plus ACC_W accumulator with clear/enable and a subtract select for the a-taps.

Test Plan:
1. After reset with no coef writes, feed frame ch0=1000, ch1=−1000 → out_valid at edge 13, sample_out ch0=1000, ch1=−1000; busy high edges 1–12.
2. Write b0=32768 (0.5), feed ch0=−3, ch1=7 → next frame uses new b0; outputs −1 (round of −1.5) and 4 (round of 3.5).
3. Write b0=131071 (≈2.0); feed 32767 and −32768 → outputs saturate to 32767 and −32768.
4. Set b0=b1=32768 (two-tap average); feed an impulse of 20000 then zeros → ch0 output sequence 10000, 10000, 0, 0.
5. Assert sample_valid again 4 edges after acceptance → frame dropped, overrun=1 and stays set; the first frame completes normally.
6. Deassert reset_n at edge 8 of a frame → no out_valid, all outputs 0; the next frame after release behaves as unity pass-through.
